// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: PC sizing, halt opcode,
// bubble word and FSM state encodings.
package fetch_stage_pkg;

    localparam int PC_SIZE      = 10;
    localparam int PC_W_DEFAULT = PC_SIZE + 1;

    localparam logic [31:0] HALT_OPCODE      = 32'hFC000000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h00000000;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_REQ    = 3'd1,
        FS_STALL  = 3'd2,
        FS_DRAIN  = 3'd3,
        FS_HALTED = 3'd4
    } fetch_state_t;

    function automatic logic is_halt_word(input logic [31:0] word);
        return word == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction word and its PC+1.
// Used both as the IF/ID-facing output register and as the skid buffer.
module fetch_skid
    import fetch_stage_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            load,
    input  logic [31:0]     data_in,
    input  logic [PC_W-1:0] pc1_in,
    output logic            valid,
    output logic [31:0]     data,
    output logic [PC_W-1:0] pc1
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= NOP_WORD;
            pc1   <= '0;
        end else if (clear) begin
            // An empty entry always reads as a bubble.
            valid <= 1'b0;
            data  <= NOP_WORD;
            pc1   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            pc1   <= pc1_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, variable-latency imem handshake,
// skid buffering under stalls, redirects and stale-response draining.
// Optional halt detection is built when FETCH_HALT_DETECT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            pc_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump_sel,
    input  logic [PC_W-1:0] jump_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instruc_out,
    output logic [PC_W-1:0] PC_plus_1_out,
    output logic            fetch_valid,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next, addr;
    logic [PC_W-1:0] target, resp_pc1;
    logic            redirect, accept, good_resp, out_free, halt_hit;

    logic            out_valid, out_clear, out_load;
    logic [31:0]     out_din;
    logic [PC_W-1:0] out_pc1_din;

    logic            skid_valid, skid_clear, skid_load;
    logic [31:0]     skid_data;
    logic [PC_W-1:0] skid_pc1;

    assign redirect  = branch_taken | jump_sel;
    assign target    = branch_taken ? branch_target : jump_target;
    assign accept    = enable & pc_write;
    assign good_resp = (state == FS_REQ) & imem_ready & ~redirect;
    assign out_free  = ~out_valid | accept;
    assign resp_pc1  = addr + PC_ONE;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = good_resp & is_halt_word(imem_rdata);
    assign halted   = (state == FS_HALTED);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // The request lives in REQ and in DRAIN, where the stale address is held.
    assign imem_req    = (state == FS_REQ) | (state == FS_DRAIN);
    assign imem_addr   = addr;
    assign fetch_valid = out_valid;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        out_clear   = 1'b0;
        out_load    = 1'b0;
        out_din     = imem_rdata;
        out_pc1_din = resp_pc1;
        skid_clear  = 1'b0;
        skid_load   = 1'b0;

        if (redirect) begin
            out_clear  = 1'b1;
            skid_clear = 1'b1;
        end else begin
            if (accept && skid_valid) begin
                out_load    = 1'b1;
                out_din     = skid_data;
                out_pc1_din = skid_pc1;
                skid_clear  = 1'b1;
            end else if (good_resp && out_free) begin
                out_load = 1'b1;
            end else if (accept) begin
                out_clear = 1'b1;
            end
            if (good_resp && !out_free) begin
                skid_load = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;

        if (redirect) begin
            pc_next = target;
        end else if (good_resp && !halt_hit) begin
            pc_next = pc + PC_ONE;
        end

        case (state)
            FS_IDLE: begin
                if (redirect || enable) state_next = FS_REQ;
            end
            FS_REQ: begin
                if (redirect) begin
                    // A redirect that coincides with ready retires the old request.
                    state_next = imem_ready ? FS_REQ : FS_DRAIN;
`ifdef FETCH_HALT_DETECT_EN
                end else if (halt_hit) begin
                    state_next = FS_HALTED;
`endif
                end else if (good_resp && !out_free) begin
                    state_next = FS_STALL;
                end
            end
            FS_STALL: begin
                if (redirect || accept) state_next = FS_REQ;
            end
            FS_DRAIN: begin
                if (imem_ready) state_next = FS_REQ;
            end
`ifdef FETCH_HALT_DETECT_EN
            FS_HALTED: begin
                if (redirect) state_next = FS_REQ;
            end
`endif
            default: state_next = FS_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= FS_IDLE;
            pc    <= RESET_PC;
            addr  <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            // The address only follows pc once no stale request is outstanding.
            if (state_next != FS_DRAIN) addr <= pc_next;
        end
    end

    fetch_skid #(.PC_W(PC_W), .NOP_WORD(NOP_WORD)) u_out (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (out_clear),
        .load    (out_load),
        .data_in (out_din),
        .pc1_in  (out_pc1_din),
        .valid   (out_valid),
        .data    (instruc_out),
        .pc1     (PC_plus_1_out)
    );

    fetch_skid #(.PC_W(PC_W), .NOP_WORD(NOP_WORD)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (skid_clear),
        .load    (skid_load),
        .data_in (imem_rdata),
        .pc1_in  (resp_pc1),
        .valid   (skid_valid),
        .data    (skid_data),
        .pc1     (skid_pc1)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async reset,
// randomized run against an in-order fetch scoreboard, optional halt sequence.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int PC_W = 11;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            enable, pc_write, branch_taken, jump_sel;
    logic [PC_W-1:0] branch_target, jump_target;
    logic            imem_req, imem_ready;
    logic [PC_W-1:0] imem_addr, PC_plus_1_out;
    logic [31:0]     imem_rdata, instruc_out;
    logic            fetch_valid, halted;

    int compared   = 0;
    int mismatched = 0;

    // Memory responder state
    int              cnt      = 0;
    int              lat_cur  = 1;
    int              lat_cfg  = 1;
    bit              lat_rand = 1'b0;
    bit              halt_on  = 1'b0;
    logic [PC_W-1:0] halt_addr = '0;
    logic            pre_req, pre_ready;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_sel      (jump_sel),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .instruc_out   (instruc_out),
        .PC_plus_1_out (PC_plus_1_out),
        .fetch_valid   (fetch_valid),
        .halted        (halted)
    );

    function automatic logic [31:0] memf(input logic [PC_W-1:0] a);
        if (halt_on && a == halt_addr) return HALT_OPCODE;
        return 32'(a) + 32'd100;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // Drive the memory response for the current request, clock once, sample at +1.
    task automatic step();
        if (!imem_req) begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEADBEEF;
        end else begin
            if (cnt == 0) lat_cur = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
            imem_ready = (cnt + 1 >= lat_cur);
            imem_rdata = imem_ready ? memf(imem_addr) : 32'hDEADBEEF;
        end
        pre_req   = imem_req;
        pre_ready = imem_ready;
        @(posedge clock);
        #1;
        if (pre_req) cnt = pre_ready ? 0 : cnt + 1;
        else         cnt = 0;
    endtask

    task automatic drive(input logic en, input logic pw, input logic br, input logic [PC_W-1:0] bt,
                         input logic js, input logic [PC_W-1:0] jt);
        enable = en; pc_write = pw;
        branch_taken = br; branch_target = bt;
        jump_sel = js; jump_target = jt;
    endtask

    typedef struct {
        logic            en, pw, br, js;
        logic [PC_W-1:0] bt, jt;
        int              lat;
        logic            req;
        logic [PC_W-1:0] addr;
        logic            valid;
        logic [31:0]     instr;
        logic [PC_W-1:0] pc1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic pw, input logic br, input logic [PC_W-1:0] bt,
                       input logic js, input logic [PC_W-1:0] jt, input int lat,
                       input logic req, input logic [PC_W-1:0] addr, input logic valid,
                       input logic [31:0] instr, input logic [PC_W-1:0] pc1);
        vec_t v;
        v.en = en; v.pw = pw; v.br = br; v.bt = bt; v.js = js; v.jt = jt; v.lat = lat;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc1 = pc1;
        vecs.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req"},    32'(imem_req),      32'd0);
        check({tag, ".addr"},   32'(imem_addr),     32'd0);
        check({tag, ".valid"},  32'(fetch_valid),   32'd0);
        check({tag, ".instr"},  instruc_out,        32'd0);
        check({tag, ".pc1"},    32'(PC_plus_1_out), 32'd0);
        check({tag, ".halted"}, 32'(halted),        32'd0);
    endtask

    initial begin
        logic            acc, rd, pv;
        logic [31:0]     pw_word;
        logic [PC_W-1:0] tgt, pp1, paddr, exp_pc;
        int              r, consumed;

        reset_n    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        drive(0, 0, 0, '0, 0, '0);
        #12;
        check_reset_values("reset");
        reset_n = 1'b1;

        // en pw br bt js jt lat | req addr valid instr pc1
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h000, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h001, 1, 100,  11'h001);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h002, 1, 101,  11'h002);
        add(1, 0, 0, 11'h000, 0, 11'h000, 1,  0, 11'h003, 1, 101,  11'h002);
        add(1, 0, 0, 11'h000, 0, 11'h000, 1,  0, 11'h003, 1, 101,  11'h002);
        add(1, 0, 0, 11'h000, 0, 11'h000, 1,  0, 11'h003, 1, 101,  11'h002);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h003, 1, 102,  11'h003);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h004, 1, 103,  11'h004);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h005, 1, 104,  11'h005);
        add(1, 1, 0, 11'h000, 0, 11'h000, 4,  1, 11'h005, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 4,  1, 11'h005, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 4,  1, 11'h005, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 4,  1, 11'h006, 1, 105,  11'h006);
        add(1, 1, 1, 11'h040, 0, 11'h000, 4,  1, 11'h006, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 4,  1, 11'h006, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 4,  1, 11'h006, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 4,  1, 11'h040, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h041, 1, 164,  11'h041);
        add(1, 1, 1, 11'h010, 1, 11'h020, 1,  1, 11'h010, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h011, 1, 116,  11'h011);
        add(1, 1, 0, 11'h000, 1, 11'h7FF, 1,  1, 11'h7FF, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h000, 1, 2147, 11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h001, 1, 100,  11'h001);
        add(0, 0, 1, 11'h020, 0, 11'h000, 1,  1, 11'h020, 0, 0,    11'h000);
        add(0, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h021, 1, 132,  11'h021);
        add(0, 1, 0, 11'h000, 0, 11'h000, 1,  0, 11'h000, 1, 132,  11'h021);
        add(1, 1, 1, 11'h030, 0, 11'h000, 1,  1, 11'h030, 0, 0,    11'h000);
        add(1, 1, 0, 11'h000, 0, 11'h000, 1,  1, 11'h031, 1, 148,  11'h031);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].pw, vecs[i].br, vecs[i].bt, vecs[i].js, vecs[i].jt);
            lat_cfg = vecs[i].lat;
            step();
            check($sformatf("row%0d.req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req)
                check($sformatf("row%0d.addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            check($sformatf("row%0d.valid", i), 32'(fetch_valid), 32'(vecs[i].valid));
            check($sformatf("row%0d.instr", i), instruc_out, vecs[i].instr);
            check($sformatf("row%0d.pc1", i), 32'(PC_plus_1_out), 32'(vecs[i].pc1));
            check($sformatf("row%0d.halted", i), 32'(halted), 32'd0);
        end

        // Asynchronous reset while a request is outstanding and a word is held.
        drive(1, 1, 0, '0, 0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        cnt     = 0;

        // Randomized run: consumed words must follow program order from the last redirect.
        lat_rand = 1'b1;
        exp_pc   = '0;
        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                  r < 3, PC_W'($urandom), (r >= 2 && r < 5), PC_W'($urandom));
            acc     = enable & pc_write;
            rd      = branch_taken | jump_sel;
            tgt     = branch_taken ? branch_target : jump_target;
            pv      = fetch_valid;
            pw_word = instruc_out;
            pp1     = PC_plus_1_out;
            paddr   = imem_addr;
            if (!pv) check("rnd.bubble", {pw_word[31:0] | 32'(pp1)}, 32'd0);
            step();
            if (pre_req && !pre_ready)
                check("rnd.addr_hold", {31'(imem_addr), imem_req}, {31'(paddr), 1'b1});
            if (rd) begin
                exp_pc = tgt;
                check("rnd.redirect_bubble", 32'(fetch_valid), 32'd0);
            end else if (acc && pv) begin
                check("rnd.word", pw_word, memf(exp_pc));
                check("rnd.pc1", 32'(pp1), 32'(exp_pc + PC_W'(1)));
                exp_pc = exp_pc + PC_W'(1);
                consumed++;
            end
        end
        check("rnd.progress", 32'(consumed >= 200), 32'd1);
        lat_rand = 1'b0;

`ifdef FETCH_HALT_DETECT_EN
        // Halt word at address 3: delivered, fetch stops, a jump restarts it.
        reset_n = 1'b0;
        drive(1, 1, 0, '0, 0, '0);
        #1;
        reset_n   = 1'b1;
        cnt       = 0;
        lat_cfg   = 1;
        halt_on   = 1'b1;
        halt_addr = 11'h003;
        for (int k = 0; k < 5; k++) step();
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.instr", instruc_out, HALT_OPCODE);
        check("halt.valid", 32'(fetch_valid), 32'd1);
        check("halt.pc1", 32'(PC_plus_1_out), 32'd4);
        check("halt.req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("halt.hold_req", 32'(imem_req), 32'd0);
            check("halt.hold_halted", 32'(halted), 32'd1);
        end
        drive(1, 1, 0, '0, 1, 11'h000);
        step();
        check("halt.restart_halted", 32'(halted), 32'd0);
        check("halt.restart_req", 32'(imem_req), 32'd1);
        check("halt.restart_addr", 32'(imem_addr), 32'd0);
        drive(1, 1, 0, '0, 0, '0);
        step();
        check("halt.restart_instr", instruc_out, 32'd100);
        halt_on = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
